// File: rtl/rc_input_pkg.sv
// Shared types and default timing constants for the RC car input-conditioning blocks.
package rc_input_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEF_CLK_HZ          = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms at 50 MHz
  localparam int DEF_LONG_CYCLES     = 50_000_000;  // 1 s at 50 MHz

endpackage

// File: rtl/btn_debounce_if.sv
// Raw button pin plus the conditioned level and strobes handed to downstream logic.
interface btn_debounce_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic toggle;

  // master: the debouncer itself; slave: the pin source and the consumers
  modport master (
    input  btn_raw,
    output btn_level, press_pulse, release_pulse, long_pulse, toggle
  );

  modport slave (
    output btn_raw,
    input  btn_level, press_pulse, release_pulse, long_pulse, toggle
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous KEY/SW pins; reset value selects the idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, and derive press/release/long strobes and a toggle bit.
module btn_debounce
  import rc_input_pkg::*;
#(
  parameter int CLK_HZ          = DEF_CLK_HZ,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / (DEF_CLK_HZ / DEF_DEBOUNCE_CYCLES),
  parameter int LONG_CYCLES     = CLK_HZ / (DEF_CLK_HZ / DEF_LONG_CYCLES),
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  btn_debounce_if.master btn
);

  localparam int   CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int   HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic POL    = (ACTIVE_LOW != 0);

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  // Value the hold counter holds on the edge before it steps to LONG_CYCLES-1.
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 2);

  btn_state_t        state;
  logic [CNT_W-1:0]  db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              sync_q;
  logic              s;
  logic              level_q, press_q, release_q, long_q, toggle_q;

  // Sync flops idle at the not-pressed pin level so leaving reset never looks like a press.
  sync_2ff #(
    .RESET_VAL (POL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn.btn_raw),
    .q     (sync_q)
  );

  assign s = sync_q ^ POL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RELEASED;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;

      // Hold time runs through release bounce too, so a long hold is not reset by chatter.
      if (state == PRESSED || state == RELEASE_WAIT) begin
        if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        if (hold_cnt == HOLD_FIRE) begin
          long_q <= 1'b1;
        end
      end

      case (state)
        RELEASED: begin
          if (s) begin
            state  <= PRESS_WAIT;
            db_cnt <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s) begin
            state <= RELEASED;
          end else if (db_cnt == DB_LAST) begin
            state    <= PRESSED;
            level_q  <= 1'b1;
            press_q  <= 1'b1;
            toggle_q <= ~toggle_q;
            hold_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        PRESSED: begin
          if (!s) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state     <= RELEASED;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        default: state <= RELEASED;
      endcase
    end
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.long_pulse    = long_q;
  assign btn.toggle        = toggle_q;

endmodule
